// File: rtl/spi_rb_frame_pkg.sv
// Shared definitions for the SPI frame reader: FSM encoding, ADC frame size, counter sizing helper.
package spi_rb_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCK_HI,
        ST_SCK_LO,
        ST_HOLD
    } state_e;

    // ADS131E08: 3 status bytes + 8 channels x 24 bits
    localparam int ADS_FRAME_BYTES = 27;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_rb_frame_if.sv
// Parallel side of the SPI frame reader: start/busy/done handshake and the received-byte bus.
interface spi_rb_frame_if;
    logic       I_rx_en;
    logic       O_busy;
    logic       O_rx_done;
    logic [7:0] O_byte;
    logic       O_byte_vld;
    logic [7:0] O_byte_idx;

    modport master (output I_rx_en, input O_busy, O_rx_done, O_byte, O_byte_vld, O_byte_idx);
    modport slave  (input I_rx_en, output O_busy, O_rx_done, O_byte, O_byte_vld, O_byte_idx);
endinterface

// File: rtl/spi_rb_frame.sv
// SPI master reader (CPOL=0): clocks FRAME_BYTES bytes in from MISO, MSB first,
// strobing each completed byte with its frame index.
module spi_rb_frame
    import spi_rb_frame_pkg::*;
#(
    parameter int FRAME_BYTES = ADS_FRAME_BYTES,
    parameter int SCK_DIV     = 1,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2
) (
    input  logic          I_clk,
    input  logic          I_rst,
    spi_rb_frame_if.slave bus,
    input  logic          I_spi_miso,
    output logic          O_spi_sck,
    output logic          O_spi_cs,
    output logic          O_spi_mosi
);

    localparam int CNT_W = $clog2(max3(SCK_DIV, CS_SETUP, CS_HOLD) + 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [7:0]       LAST_BYTE  = 8'(FRAME_BYTES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             vld_q, vld_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       idx_q, idx_d;
    logic [6:0]       sh_q, sh_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       bcnt_q, bcnt_d;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            byte_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            bit_q   <= 3'd7;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        sck_d   = sck_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        vld_d   = 1'b0;
        byte_d  = byte_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.I_rx_en) begin
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 3'd7;
                    bcnt_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = ST_SCK_HI;
                end
            end
            ST_SCK_HI: begin
                // sample on the falling edge; the ADC launched this bit on our rising edge
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b0;
                    sh_d    = {sh_q[5:0], I_spi_miso};
                    state_d = ST_SCK_LO;
                    if (bit_q == 3'd0) begin
                        byte_d = {sh_q, I_spi_miso};
                        idx_d  = bcnt_q;
                        vld_d  = 1'b1;
                    end
                end
            end
            ST_SCK_LO: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (bit_q != 3'd0 || bcnt_q != LAST_BYTE) begin
                        sck_d   = 1'b1;
                        bit_d   = bit_q - 3'd1;
                        bcnt_d  = (bit_q == 3'd0) ? bcnt_q + 8'd1 : bcnt_q;
                        state_d = ST_SCK_HI;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.O_busy     = busy_q;
    assign bus.O_rx_done  = done_q;
    assign bus.O_byte     = byte_q;
    assign bus.O_byte_vld = vld_q;
    assign bus.O_byte_idx = idx_q;
    assign O_spi_sck      = sck_q;
    assign O_spi_cs       = cs_q;
    assign O_spi_mosi     = 1'b0;

endmodule

// File: tb/tb_spi_rb_frame.sv
// Bench for spi_rb_frame: three configurations (2B/div1, 2B/div3, 27B/div1) driven by an ADC MISO model.
module tb_spi_rb_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[3];
    logic       rx_en[3];
    logic       miso[3];
    logic       sck[3], cs[3], mosi[3], busy[3], done[3], vld[3];
    logic [7:0] ob[3], oidx[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_rb_frame_if bus();
        assign bus.I_rx_en = rx_en[g];
        assign busy[g] = bus.O_busy;
        assign done[g] = bus.O_rx_done;
        assign ob[g]   = bus.O_byte;
        assign vld[g]  = bus.O_byte_vld;
        assign oidx[g] = bus.O_byte_idx;
        spi_rb_frame #(
            .FRAME_BYTES(g == 2 ? 27 : 2),
            .SCK_DIV    (g == 1 ? 3 : 1),
            .CS_SETUP   (2),
            .CS_HOLD    (2)
        ) u_dut (
            .I_clk     (clk),
            .I_rst     (rst[g]),
            .bus       (bus),
            .I_spi_miso(miso[g]),
            .O_spi_sck (sck[g]),
            .O_spi_cs  (cs[g]),
            .O_spi_mosi(mosi[g])
        );
    end

    int total = 0;
    int bad   = 0;

    // reference: frame contents per instance, and timing from the frame rules
    logic [7:0] tx[3][27];
    function automatic int fb_of(input int g);  return (g == 2) ? 27 : 2; endfunction
    function automatic int div_of(input int g); return (g == 1) ? 3 : 1;  endfunction
    function automatic int exp_cs_len(input int g); return 2 + 16 * div_of(g) * fb_of(g) + 2; endfunction

    // observations gathered on the falling clock edge
    logic [7:0] q_b[3][$];
    logic [7:0] q_i[3][$];
    int cs_lens[3][$];
    int gaps[3][$];
    int rises[3], done_cnt[3], done_mis[3], mosi_hi[3], hi_bad[3], lo_bad[3], nfr[3];
    int lo_run[3], hi_run[3], ph_run[3], fr_r[3], bitpos[3];
    bit p_cs[3], p_sck[3];

    initial begin
        for (int g = 0; g < 3; g++) begin
            miso[g] = 1'b0; p_cs[g] = 1'b1; p_sck[g] = 1'b0;
            lo_run[g] = 0; hi_run[g] = 0; ph_run[g] = 0; fr_r[g] = 0; bitpos[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (vld[g] === 1'b1) begin q_b[g].push_back(ob[g]); q_i[g].push_back(oidx[g]); end
                if (done[g] === 1'b1) begin
                    done_cnt[g]++;
                    if (!(cs[g] === 1'b1 && !p_cs[g])) done_mis[g]++;
                end
                if (cs[g] === 1'b0) begin
                    if (p_cs[g] && nfr[g] > 0) gaps[g].push_back(hi_run[g]);
                    if (p_cs[g]) hi_run[g] = 0;
                    lo_run[g]++;
                    if (mosi[g] !== 1'b0) mosi_hi[g]++;
                end else begin
                    if (!p_cs[g]) begin cs_lens[g].push_back(lo_run[g]); nfr[g]++; lo_run[g] = 0; end
                    hi_run[g]++; bitpos[g] = 0; fr_r[g] = 0;
                end
                if (sck[g] !== p_sck[g]) begin
                    if (sck[g] === 1'b1) begin
                        if (fr_r[g] > 0 && ph_run[g] != div_of(g)) lo_bad[g]++;
                        rises[g]++; fr_r[g]++;
                        // ADC launches the next bit on each SCK rise, MSB first
                        miso[g] = (bitpos[g] < 8 * fb_of(g)) ? tx[g][bitpos[g] / 8][7 - (bitpos[g] % 8)] : 1'b0;
                        bitpos[g]++;
                    end else if (ph_run[g] != div_of(g)) hi_bad[g]++;
                    ph_run[g] = 1;
                end else ph_run[g]++;
                p_cs[g]  = (cs[g] === 1'b1);
                p_sck[g] = (sck[g] === 1'b1);
            end
        end
    end

    task automatic clear_mon(input int g);
        q_b[g].delete(); q_i[g].delete(); cs_lens[g].delete(); gaps[g].delete();
        rises[g] = 0; done_cnt[g] = 0; done_mis[g] = 0; mosi_hi[g] = 0;
        hi_bad[g] = 0; lo_bad[g] = 0; nfr[g] = 0;
    endtask

    task automatic start_frame(input int g);
        @(posedge clk); #1 rx_en[g] = 1'b1;
        @(posedge clk); #1 rx_en[g] = 1'b0;
    endtask

    task automatic wait_dn(input int g, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt[g] >= n) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            total++; if (cs[g] !== 1'b1)   begin bad++; $display("FAIL rst_cs[%0d] got=%b want=1", g, cs[g]); end
            total++; if (sck[g] !== 1'b0)  begin bad++; $display("FAIL rst_sck[%0d] got=%b want=0", g, sck[g]); end
            total++; if (busy[g] !== 1'b0 || done[g] !== 1'b0 || vld[g] !== 1'b0 || mosi[g] !== 1'b0)
                begin bad++; $display("FAIL rst_flags[%0d] got busy=%b done=%b vld=%b mosi=%b want 0000", g, busy[g], done[g], vld[g], mosi[g]); end
            total++; if (ob[g] !== 8'h00 || oidx[g] !== 8'h00)
                begin bad++; $display("FAIL rst_bus[%0d] got byte=%h idx=%h want 00 00", g, ob[g], oidx[g]); end
        end
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin rst[g] = 1'b0; clear_mon(g); end
    endtask

    task automatic test_basic();
        bit ok;
        tx[0][0] = 8'hA5; tx[0][1] = 8'h3C;
        clear_mon(0);
        start_frame(0);
        total++; if (cs[0] !== 1'b0 || busy[0] !== 1'b1) begin bad++; $display("FAIL basic_start got cs=%b busy=%b want cs=0 busy=1", cs[0], busy[0]); end
        wait_dn(0, 1, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got no rx_done want rx_done"); end
        total++; if (q_b[0].size() != 2) begin bad++; $display("FAIL basic_nvld got=%0d want=2", q_b[0].size()); end
        for (int i = 0; i < q_b[0].size() && i < 2; i++) begin
            total++; if (q_b[0][i] !== tx[0][i] || q_i[0][i] !== 8'(i))
                begin bad++; $display("FAIL basic_byte%0d got=%h/%0d want=%h/%0d", i, q_b[0][i], q_i[0][i], tx[0][i], i); end
        end
        total++; if (cs_lens[0].size() != 1 || cs_lens[0][0] != exp_cs_len(0))
            begin bad++; $display("FAIL basic_cslen got=%0d frames=%0d want=%0d", (cs_lens[0].size() > 0) ? cs_lens[0][0] : -1, cs_lens[0].size(), exp_cs_len(0)); end
        total++; if (rises[0] != 16) begin bad++; $display("FAIL basic_sck got=%0d want=16", rises[0]); end
        total++; if (done_cnt[0] != 1 || done_mis[0] != 0) begin bad++; $display("FAIL basic_done got=%0d misplaced=%0d want 1 0", done_cnt[0], done_mis[0]); end
        total++; if (busy[0] !== 1'b0 || mosi_hi[0] != 0) begin bad++; $display("FAIL basic_idle got busy=%b mosi_hi=%0d want 0 0", busy[0], mosi_hi[0]); end
    endtask

    task automatic test_div3();
        bit ok;
        tx[1][0] = 8'hA5; tx[1][1] = 8'h3C;
        clear_mon(1);
        start_frame(1);
        wait_dn(1, 1, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL div3_timeout got no rx_done want rx_done"); end
        total++; if (q_b[1].size() != 2) begin bad++; $display("FAIL div3_nvld got=%0d want=2", q_b[1].size()); end
        for (int i = 0; i < q_b[1].size() && i < 2; i++) begin
            total++; if (q_b[1][i] !== tx[1][i] || q_i[1][i] !== 8'(i))
                begin bad++; $display("FAIL div3_byte%0d got=%h/%0d want=%h/%0d", i, q_b[1][i], q_i[1][i], tx[1][i], i); end
        end
        total++; if (cs_lens[1].size() != 1 || cs_lens[1][0] != exp_cs_len(1))
            begin bad++; $display("FAIL div3_cslen got=%0d want=%0d", (cs_lens[1].size() > 0) ? cs_lens[1][0] : -1, exp_cs_len(1)); end
        total++; if (hi_bad[1] != 0 || lo_bad[1] != 0) begin bad++; $display("FAIL div3_phase got hi_bad=%0d lo_bad=%0d want 0 0", hi_bad[1], lo_bad[1]); end
        total++; if (rises[1] != 16) begin bad++; $display("FAIL div3_sck got=%0d want=16", rises[1]); end
    endtask

    task automatic test_ignore_start();
        bit ok;
        for (int i = 0; i < 2; i++) tx[0][i] = 8'($urandom);
        clear_mon(0);
        start_frame(0);
        repeat (8) @(posedge clk);
        #1 rx_en[0] = 1'b1;
        @(posedge clk); #1 rx_en[0] = 1'b0;
        wait_dn(0, 1, 200, ok);
        repeat (50) @(negedge clk);
        total++; if (!ok || done_cnt[0] != 1 || nfr[0] != 1)
            begin bad++; $display("FAIL ignore_frames got done=%0d frames=%0d want 1 1", done_cnt[0], nfr[0]); end
        total++; if (rises[0] != 16) begin bad++; $display("FAIL ignore_sck got=%0d want=16", rises[0]); end
        for (int i = 0; i < q_b[0].size() && i < 2; i++) begin
            total++; if (q_b[0][i] !== tx[0][i]) begin bad++; $display("FAIL ignore_byte%0d got=%h want=%h", i, q_b[0][i], tx[0][i]); end
        end
    endtask

    task automatic test_rst_mid();
        bit ok, ps;
        int r;
        ps = 1'b0; r = 0;
        for (int i = 0; i < 2; i++) tx[0][i] = 8'($urandom);
        clear_mon(0);
        start_frame(0);
        for (int i = 0; i < 100 && r < 5; i++) begin
            @(negedge clk);
            if (sck[0] === 1'b1 && !ps) r++;
            ps = (sck[0] === 1'b1);
        end
        total++; if (r != 5 || sck[0] !== 1'b1) begin bad++; $display("FAIL rstmid_reach got rises=%0d sck=%b want 5 1", r, sck[0]); end
        rst[0] = 1'b1;
        @(posedge clk); #1;
        total++; if (cs[0] !== 1'b1 || sck[0] !== 1'b0 || busy[0] !== 1'b0)
            begin bad++; $display("FAIL rstmid_force got cs=%b sck=%b busy=%b want 1 0 0", cs[0], sck[0], busy[0]); end
        @(posedge clk); #1 rst[0] = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (q_b[0].size() != 0 || done_cnt[0] != 0)
            begin bad++; $display("FAIL rstmid_quiet got vld=%0d done=%0d want 0 0", q_b[0].size(), done_cnt[0]); end
        clear_mon(0);
        start_frame(0);
        wait_dn(0, 1, 200, ok);
        total++; if (!ok || q_b[0].size() != 2 || rises[0] != 16)
            begin bad++; $display("FAIL rstmid_next got done=%b vld=%0d sck=%0d want 1 2 16", ok, q_b[0].size(), rises[0]); end
        for (int i = 0; i < q_b[0].size() && i < 2; i++) begin
            total++; if (q_b[0][i] !== tx[0][i] || q_i[0][i] !== 8'(i))
                begin bad++; $display("FAIL rstmid_byte%0d got=%h/%0d want=%h/%0d", i, q_b[0][i], q_i[0][i], tx[0][i], i); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        for (int i = 0; i < 2; i++) tx[0][i] = 8'($urandom);
        clear_mon(0);
        @(posedge clk); #1 rx_en[0] = 1'b1;
        for (int i = 0; i < 400 && n < 3; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1) n++;
        end
        rx_en[0] = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (n != 3 || done_cnt[0] != 3 || nfr[0] != 3 || done_mis[0] != 0)
            begin bad++; $display("FAIL b2b_frames got pulses=%0d done=%0d frames=%0d misplaced=%0d want 3 3 3 0", n, done_cnt[0], nfr[0], done_mis[0]); end
        total++; if (gaps[0].size() != 2) begin bad++; $display("FAIL b2b_ngaps got=%0d want=2", gaps[0].size()); end
        foreach (gaps[0][i]) begin
            total++; if (gaps[0][i] != 1) begin bad++; $display("FAIL b2b_gap%0d got=%0d want=1", i, gaps[0][i]); end
        end
        foreach (cs_lens[0][i]) begin
            total++; if (cs_lens[0][i] != exp_cs_len(0)) begin bad++; $display("FAIL b2b_cslen%0d got=%0d want=%0d", i, cs_lens[0][i], exp_cs_len(0)); end
        end
        total++; if (q_b[0].size() != 6) begin bad++; $display("FAIL b2b_nvld got=%0d want=6", q_b[0].size()); end
        for (int i = 0; i < q_b[0].size() && i < 6; i++) begin
            total++; if (q_b[0][i] !== tx[0][i % 2] || q_i[0][i] !== 8'(i % 2))
                begin bad++; $display("FAIL b2b_byte%0d got=%h/%0d want=%h/%0d", i, q_b[0][i], q_i[0][i], tx[0][i % 2], i % 2); end
        end
    endtask

    task automatic test_frame27();
        bit ok;
        for (int i = 0; i < 27; i++) tx[2][i] = 8'(i);
        clear_mon(2);
        start_frame(2);
        wait_dn(2, 1, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL f27_timeout got no rx_done want rx_done"); end
        total++; if (q_b[2].size() != 27) begin bad++; $display("FAIL f27_nvld got=%0d want=27", q_b[2].size()); end
        for (int i = 0; i < q_b[2].size() && i < 27; i++) begin
            total++; if (q_b[2][i] !== 8'(i) || q_i[2][i] !== 8'(i))
                begin bad++; $display("FAIL f27_byte%0d got=%h/%0d want=%h/%0d", i, q_b[2][i], q_i[2][i], i, i); end
        end
        total++; if (mosi_hi[2] != 0) begin bad++; $display("FAIL f27_mosi got=%0d high cycles want=0", mosi_hi[2]); end
        total++; if (cs_lens[2].size() != 1 || cs_lens[2][0] != exp_cs_len(2))
            begin bad++; $display("FAIL f27_cslen got=%0d want=%0d", (cs_lens[2].size() > 0) ? cs_lens[2][0] : -1, exp_cs_len(2)); end
        // second frame with random contents
        for (int i = 0; i < 27; i++) tx[2][i] = 8'($urandom);
        clear_mon(2);
        start_frame(2);
        wait_dn(2, 1, 1000, ok);
        total++; if (!ok || q_b[2].size() != 27) begin bad++; $display("FAIL f27r_nvld got=%0d want=27", q_b[2].size()); end
        for (int i = 0; i < q_b[2].size() && i < 27; i++) begin
            total++; if (q_b[2][i] !== tx[2][i]) begin bad++; $display("FAIL f27r_byte%0d got=%h want=%h", i, q_b[2][i], tx[2][i]); end
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin rst[g] = 1'b1; rx_en[g] = 1'b0; end
        test_reset();
        test_basic();
        test_div3();
        test_ignore_start();
        test_rst_mid();
        test_back_to_back();
        test_frame27();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
